// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer/FIFO-side signal bundle for the round-robin push arbiter
interface fifo_push_arbiter_if #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int LW   = 5
);
  logic [NREQ-1:0]    req;
  logic [NREQ*W-1:0]  din_flat;
  logic [NREQ-1:0]    gnt;
  logic               fifo_push;
  logic [W-1:0]       fifo_din;
  logic               fifo_pop;
  logic [LW-1:0]      level;
  logic               arb_full;
  logic               underflow_err;
  logic [NREQ*16-1:0] grant_cnt_flat;
  modport master (
    output req, din_flat, fifo_pop,
    input  gnt, fifo_push, fifo_din, level, arb_full, underflow_err, grant_cnt_flat
  );
  modport slave (
    input  req, din_flat, fifo_pop,
    output gnt, fifo_push, fifo_din, level, arb_full, underflow_err, grant_cnt_flat
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: credit-tracked round-robin burst arbiter for one FIFO write port (optional grant counters under FIFO_ARB_STATS_EN)
module fifo_push_arbiter #(
  parameter int W     = 4,
  parameter int NREQ  = 4,
  parameter int DEPTH = 16,
  parameter int BURST = 2,
  parameter int LW    = 5
) (
  input logic clk,
  input logic reset,
  fifo_push_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  typedef enum logic {IDLE, OWN} state_t;
  state_t          state_q;
  logic [IW-1:0]   owner_q, ptr_q;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [LW-1:0]   level_q, level_d;
  logic            push_q, uf_q;
  logic [W-1:0]    din_q, sel_din;
  logic [IW-1:0]   base, win;
  logic            keep, hit, can, any, dn;
  logic [NREQ-1:0] gnt;
  int              idx;
  // Winner selection: the owner keeps the port inside its burst, otherwise search upward from the owner, previous owner last
  always_comb begin
    can = reset && (level_q < LW'(DEPTH));
    base = (state_q == OWN) ? owner_q : ptr_q;
    keep = (state_q == OWN) && bus.req[owner_q] && (int'(bcnt_q) < BURST - 1);
    hit = 1'b0;
    win = base;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(base) + k;
      idx = (idx >= NREQ) ? idx - NREQ : idx;
      if (!hit && bus.req[IW'(idx)]) begin
        hit = 1'b1;
        win = IW'(idx);
      end
    end
    win = keep ? owner_q : win;
    any = can && (keep || hit);
    gnt = any ? (NREQ'(1) << win) : '0;
    sel_din = bus.din_flat[win*W +: W];
    dn = bus.fifo_pop && (level_q != '0);
    level_d = level_q + LW'(any) - LW'(dn);
    bcnt_d = (state_q == OWN && win == owner_q) ? ((int'(bcnt_q) < BURST - 1) ? bcnt_q + 1'b1 : bcnt_q) : '0;
  end
  // Ownership FSM, credit level, registered FIFO push and sticky underflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
      bcnt_q  <= '0;
      level_q <= '0;
      push_q  <= 1'b0;
      din_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      push_q  <= any;
      level_q <= level_d;
      if (any) din_q <= sel_din;
      if (bus.fifo_pop && level_q == '0) uf_q <= 1'b1;
      if (any) begin
        state_q <= OWN;
        owner_q <= win;
        ptr_q   <= win;
        bcnt_q  <= bcnt_d;
      end else if (can && state_q == OWN && bus.req == '0) begin
        state_q <= IDLE;
        ptr_q   <= owner_q;
      end
    end
  end
  assign bus.gnt           = gnt;
  assign bus.fifo_push     = push_q;
  assign bus.fifo_din      = din_q;
  assign bus.level         = level_q;
  assign bus.arb_full      = (level_q == LW'(DEPTH));
  assign bus.underflow_err = uf_q;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  // Per-requester saturating grant counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!reset) cnt_q[i] <= '0;
      else if (gnt[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign bus.grant_cnt_flat[g*16 +: 16] = cnt_q[g];
  end
`else
  assign bus.grant_cnt_flat = '0;
`endif
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
`ifdef FIFO_ARB_STATS_EN
  localparam logic [63:0] CNT_MID = 64'h0000_0000_0000_0002;
`else
  localparam logic [63:0] CNT_MID = 64'h0;
`endif
  fifo_push_arbiter_if #(.W(4), .NREQ(4), .LW(5)) bus ();
  fifo_push_arbiter #(.W(4), .NREQ(4), .DEPTH(16), .BURST(2), .LW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task test_reset;
    reset = 1'b0; bus.req = 4'hF; bus.din_flat = 16'h3210; bus.fifo_pop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %h required %h", bus.gnt, 4'h0); end
    checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b required 0", bus.fifo_push); end
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", bus.level); end
    checks++; if (bus.underflow_err !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b required 0", bus.underflow_err); end
    checks++; if (bus.arb_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", bus.arb_full); end
    checks++; if (bus.grant_cnt_flat !== 64'h0) begin errors++; $display("FAIL reset_cnt: got %h required 0", bus.grant_cnt_flat); end
  endtask
  task test_fill;
    logic [3:0] exp_g [16] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8,
                                4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
    logic [3:0] exp_d [16] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
                                4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    reset = 1'b1; #1;
    for (int c = 0; c < 16; c++) begin
      checks++; if (bus.gnt !== exp_g[c]) begin errors++; $display("FAIL fill_gnt[%0d]: got %h required %h", c, bus.gnt, exp_g[c]); end
      checks++; if (bus.level !== 5'(c)) begin errors++; $display("FAIL fill_level[%0d]: got %0d required %0d", c, bus.level, c); end
      @(negedge clk);
      checks++; if (bus.fifo_push !== 1'b1) begin errors++; $display("FAIL fill_push[%0d]: got %b required 1", c, bus.fifo_push); end
      checks++; if (bus.fifo_din !== exp_d[c]) begin errors++; $display("FAIL fill_din[%0d]: got %h required %h", c, bus.fifo_din, exp_d[c]); end
      #1;
    end
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d required 16", bus.level); end
    checks++; if (bus.arb_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b required 1", bus.arb_full); end
    checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL full_gnt: got %h required 0", bus.gnt); end
    @(negedge clk); #1;
    checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL full_push: got %b required 0", bus.fifo_push); end
    checks++; if (bus.fifo_din !== 4'd3) begin errors++; $display("FAIL full_din_hold: got %h required 3", bus.fifo_din); end
    checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL full_gnt2: got %h required 0", bus.gnt); end
  endtask
  task test_pop_refill;
    bus.fifo_pop = 1'b1; #1;
    checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL pop1_gnt: got %h required 0", bus.gnt); end
    @(negedge clk);
    checks++; if (bus.level !== 5'd15) begin errors++; $display("FAIL pop1_level: got %0d required 15", bus.level); end
    bus.fifo_pop = 1'b0; #1;
    checks++; if (bus.gnt !== 4'h1) begin errors++; $display("FAIL refill1_gnt: got %h required 1", bus.gnt); end
    @(negedge clk);
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL refill1_level: got %0d required 16", bus.level); end
    checks++; if (bus.fifo_din !== 4'd0 || bus.fifo_push !== 1'b1) begin errors++; $display("FAIL refill1_out: got push %b din %h required push 1 din 0", bus.fifo_push, bus.fifo_din); end
    #1;
    checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL refill1_stall: got %h required 0", bus.gnt); end
    bus.fifo_pop = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.level !== 5'd15) begin errors++; $display("FAIL pop2_level: got %0d required 15", bus.level); end
    checks++; if (bus.gnt !== 4'h1) begin errors++; $display("FAIL keep_gnt: got %h required 1", bus.gnt); end
    @(negedge clk);
    checks++; if (bus.level !== 5'd15) begin errors++; $display("FAIL grant_pop_level: got %0d required 15", bus.level); end
    bus.fifo_pop = 1'b0; #1;
    checks++; if (bus.gnt !== 4'h2) begin errors++; $display("FAIL rotate_gnt: got %h required 2", bus.gnt); end
    @(negedge clk); #1;
    checks++; if (bus.level !== 5'd16 || bus.fifo_din !== 4'd1) begin errors++; $display("FAIL rotate_out: got level %0d din %h required level 16 din 1", bus.level, bus.fifo_din); end
    checks++; if (bus.gnt !== 4'h0 || bus.arb_full !== 1'b1) begin errors++; $display("FAIL refull: got gnt %h full %b required gnt 0 full 1", bus.gnt, bus.arb_full); end
  endtask
  task test_drain_underflow;
    bus.req = 4'h0; bus.fifo_pop = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (bus.level !== 5'(16 - k)) begin errors++; $display("FAIL drain_level[%0d]: got %0d required %0d", k, bus.level, 16 - k); end
      @(negedge clk); #1;
    end
    checks++; if (bus.level !== 5'd0 || bus.underflow_err !== 1'b0) begin errors++; $display("FAIL drained: got level %0d uf %b required level 0 uf 0", bus.level, bus.underflow_err); end
    @(negedge clk); #1;
    checks++; if (bus.underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b required 1", bus.underflow_err); end
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL underflow_level: got %0d required 0", bus.level); end
    bus.fifo_pop = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b required 1", bus.underflow_err); end
  endtask
  task test_single;
    bus.req = 4'b0100; bus.din_flat = 16'h0A00; #1;
    checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL single_pre_push: got %b required 0", bus.fifo_push); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt[%0d]: got %h required 4", c, bus.gnt); end
      @(negedge clk);
      checks++; if (bus.fifo_push !== 1'b1 || bus.fifo_din !== 4'hA) begin errors++; $display("FAIL single_out[%0d]: got push %b din %h required push 1 din a", c, bus.fifo_push, bus.fifo_din); end
      checks++; if (bus.level !== 5'(c + 1)) begin errors++; $display("FAIL single_level[%0d]: got %0d required %0d", c, bus.level, c + 1); end
      #1;
    end
  endtask
  task test_reset_mid_burst;
    reset = 1'b0; bus.req = 4'hF; bus.din_flat = 16'h3210;
    @(negedge clk);
    reset = 1'b1; #1;
    checks++; if (bus.gnt !== 4'h1) begin errors++; $display("FAIL mid_g0: got %h required 1", bus.gnt); end
    @(negedge clk); #1;
    checks++; if (bus.gnt !== 4'h1) begin errors++; $display("FAIL mid_g1: got %h required 1", bus.gnt); end
    @(negedge clk); #1;
    checks++; if (bus.gnt !== 4'h2) begin errors++; $display("FAIL mid_g2: got %h required 2", bus.gnt); end
    checks++; if (bus.grant_cnt_flat !== CNT_MID) begin errors++; $display("FAIL mid_cnt: got %h required %h", bus.grant_cnt_flat, CNT_MID); end
    reset = 1'b0; #1;
    checks++; if (bus.gnt !== 4'h0) begin errors++; $display("FAIL mid_rst_gnt: got %h required 0", bus.gnt); end
    @(negedge clk);
    checks++; if (bus.fifo_push !== 1'b0 || bus.level !== 5'd0 || bus.underflow_err !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got push %b level %0d uf %b required 0 0 0", bus.fifo_push, bus.level, bus.underflow_err); end
    checks++; if (bus.grant_cnt_flat !== 64'h0) begin errors++; $display("FAIL mid_rst_cnt: got %h required 0", bus.grant_cnt_flat); end
    reset = 1'b1; #1;
    checks++; if (bus.gnt !== 4'h1) begin errors++; $display("FAIL mid_first_gnt: got %h required 1", bus.gnt); end
  endtask
  initial begin
    test_reset;
    test_fill;
    test_pop_refill;
    test_drain_underflow;
    test_single;
    test_reset_mid_burst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
